// File: rtl/sprite_mover_if.sv
// Signal bundle between a sprite_mover and its surroundings: button/maze/game inputs,
// position/state outputs and the VGA pixel query with its fill answer.
interface sprite_mover_if #(
    parameter int unsigned W = 10
);
    logic         start;
    logic         ack;
    logic         left;
    logic         up;
    logic         right;
    logic         down;
    logic [3:0]   blocked;
    logic         win;
    logic         lose;
    logic [W-1:0] hCount;
    logic [W-1:0] vCount;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic [2:0]   dir;
    logic [2:0]   pending;
    logic         tick;
    logic         fill;

    modport master (
        output start, ack, left, up, right, down, blocked, win, lose, hCount, vCount,
        input  pos_x, pos_y, dir, pending, tick, fill
    );

    modport slave (
        input  start, ack, left, up, right, down, blocked, win, lose, hCount, vCount,
        output pos_x, pos_y, dir, pending, tick, fill
    );
endinterface

// File: rtl/sprite_mover.sv
// Maze sprite movement controller: direction FSM, buffered turn, rate tick and VGA fill.
// Define SPRITE_MOVER_WRAP_EN to wrap at the position bounds instead of saturating.
module sprite_mover #(
    parameter int unsigned W        = 10,
    parameter int unsigned SIZE     = 20,
    parameter int unsigned SPEED    = 1,
    parameter int unsigned TICK_DIV = 10000,
    parameter int unsigned X_MIN    = 273,
    parameter int unsigned X_MAX    = 663,
    parameter int unsigned Y_MIN    = 58,
    parameter int unsigned Y_MAX    = 490,
    parameter int unsigned X_INI    = 300,
    parameter int unsigned Y_INI    = 300
) (
    input logic           clk,
    input logic           reset,
    sprite_mover_if.slave bus
);
    typedef enum logic [2:0] {
        StIni   = 3'd0,
        StStill = 3'd1,
        StLeft  = 3'd2,
        StUp    = 3'd3,
        StRight = 3'd4,
        StDown  = 3'd5,
        StWin   = 3'd6,
        StLose  = 3'd7
    } state_e;

    typedef logic [W:0] ext_t;

    localparam int unsigned CW   = $clog2(TICK_DIV);
    localparam ext_t        Step = ext_t'(SPEED);
    localparam ext_t        Half = ext_t'(SIZE / 2);
    localparam ext_t        One  = ext_t'(1);
    localparam ext_t        XMin = ext_t'(X_MIN);
    localparam ext_t        XMax = ext_t'(X_MAX);
    localparam ext_t        YMin = ext_t'(Y_MIN);
    localparam ext_t        YMax = ext_t'(Y_MAX);
    localparam logic [W-1:0] XIni = W'(X_INI);
    localparam logic [W-1:0] YIni = W'(Y_INI);
`ifdef SPRITE_MOVER_WRAP_EN
    localparam ext_t XUnder = XMax;
    localparam ext_t XOver  = XMin;
    localparam ext_t YUnder = YMax;
    localparam ext_t YOver  = YMin;
`else
    localparam ext_t XUnder = XMin;
    localparam ext_t XOver  = XMax;
    localparam ext_t YUnder = YMin;
    localparam ext_t YOver  = YMax;
`endif

    state_e       state_q;
    logic [2:0]   pending_q;
    logic [W-1:0] pos_x_q, pos_y_q;
    logic [CW-1:0] cnt_q;
    logic         tick;
    logic [2:0]   req;
    logic         blk_req, blk_pend, blk_cur;
    logic [W-1:0] x_nxt, y_nxt;
    ext_t         x_inc, x_dec, y_inc, y_dec;

    // blocked is ordered {left, up, right, down}
    function automatic logic way_blocked(input logic [2:0] d, input logic [3:0] b);
        case (d)
            3'd2:    return b[3];
            3'd3:    return b[2];
            3'd4:    return b[1];
            3'd5:    return b[0];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        req = 3'd0;
        case ({bus.left, bus.up, bus.right, bus.down})
            4'b1000: req = 3'd2;
            4'b0100: req = 3'd3;
            4'b0010: req = 3'd4;
            4'b0001: req = 3'd5;
            default: req = 3'd0;
        endcase
        blk_req  = way_blocked(req, bus.blocked);
        blk_pend = way_blocked(pending_q, bus.blocked);
        blk_cur  = way_blocked(state_q, bus.blocked);
    end

    // Extended arithmetic keeps MIN-SPEED from wrapping below zero.
    always_comb begin
        x_inc = {1'b0, pos_x_q} + Step;
        x_dec = {1'b0, pos_x_q} - Step;
        y_inc = {1'b0, pos_y_q} + Step;
        y_dec = {1'b0, pos_y_q} - Step;
        x_nxt = pos_x_q;
        y_nxt = pos_y_q;
        if (!blk_cur) begin
            case (state_q)
                StLeft:  x_nxt = (x_dec < XMin) ? XUnder[W-1:0] : x_dec[W-1:0];
                StRight: x_nxt = (x_inc > XMax) ? XOver[W-1:0]  : x_inc[W-1:0];
                StUp:    y_nxt = (y_dec < YMin) ? YUnder[W-1:0] : y_dec[W-1:0];
                StDown:  y_nxt = (y_inc > YMax) ? YOver[W-1:0]  : y_inc[W-1:0];
                default: ;
            endcase
        end
    end

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIni;
            pending_q <= 3'd0;
            pos_x_q   <= XIni;
            pos_y_q   <= YIni;
        end else begin
            case (state_q)
                StIni: begin
                    pos_x_q   <= XIni;
                    pos_y_q   <= YIni;
                    pending_q <= 3'd0;
                    if (bus.start) state_q <= StStill;
                end
                StWin, StLose: begin
                    if (bus.ack) begin
                        state_q   <= StIni;
                        pending_q <= 3'd0;
                        pos_x_q   <= XIni;
                        pos_y_q   <= YIni;
                    end
                end
                default: begin
                    if (bus.lose) begin
                        state_q <= StLose;
                    end else if (bus.win) begin
                        state_q <= StWin;
                    end else if (req != 3'd0 && req != state_q) begin
                        if (!blk_req) begin
                            state_q   <= state_e'(req);
                            pending_q <= 3'd0;
                        end else begin
                            pending_q <= req;
                        end
                    end else if (pending_q != 3'd0 && !blk_pend) begin
                        state_q   <= state_e'(pending_q);
                        pending_q <= 3'd0;
                    end else if (state_q != StStill && blk_cur) begin
                        state_q <= StStill;
                    end
                    // Motion uses the pre-edge direction even if a turn lands on this edge.
                    if (tick) begin
                        pos_x_q <= x_nxt;
                        pos_y_q <= y_nxt;
                    end
                end
            endcase
        end
    end

    assign bus.pos_x   = pos_x_q;
    assign bus.pos_y   = pos_y_q;
    assign bus.dir     = state_q;
    assign bus.pending = pending_q;
    assign bus.tick    = tick;
    assign bus.fill    = ({1'b0, bus.hCount} + Half >= {1'b0, pos_x_q} + One) &&
                         ({1'b0, bus.hCount} <= {1'b0, pos_x_q} + Half) &&
                         ({1'b0, bus.vCount} + Half >= {1'b0, pos_y_q} + One) &&
                         ({1'b0, bus.vCount} <= {1'b0, pos_y_q} + Half);
endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with TICK_DIV = 4 and hand-computed expectations.
module tb_sprite_mover;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n;
    int   x_edge;

    always #5 clk = ~clk;

    sprite_mover_if #(.W(10)) bus ();

    sprite_mover #(
        .W(10), .SIZE(20), .SPEED(1), .TICK_DIV(4),
        .X_MIN(273), .X_MAX(663), .Y_MIN(58), .Y_MAX(490), .X_INI(300), .Y_INI(300)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Returns the number of falling edges until tick is seen high (bounded).
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.tick && cycles < 20);
        check_val("tick_seen", 32'(bus.tick), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 0; bus.ack = 0; bus.left = 0; bus.up = 0; bus.right = 0; bus.down = 0;
        bus.blocked = 4'b0000; bus.win = 0; bus.lose = 0; bus.hCount = '0; bus.vCount = '0;
        repeat (3) @(negedge clk);
        check_val("rst_dir", 32'(bus.dir), 32'd0);
        check_val("rst_pending", 32'(bus.pending), 32'd0);
        check_val("rst_pos_x", 32'(bus.pos_x), 32'd300);
        check_val("rst_pos_y", 32'(bus.pos_y), 32'd300);
        check_val("rst_tick", 32'(bus.tick), 32'd0);

        bus.hCount = 10'd291; bus.vCount = 10'd291; #1;
        check_val("fill_lo_in", 32'(bus.fill), 32'd1);
        bus.hCount = 10'd290; #1;
        check_val("fill_lo_out", 32'(bus.fill), 32'd0);
        bus.hCount = 10'd310; bus.vCount = 10'd310; #1;
        check_val("fill_hi_in", 32'(bus.fill), 32'd1);
        bus.vCount = 10'd311; #1;
        check_val("fill_hi_out", 32'(bus.fill), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        bus.start = 1;
        @(negedge clk);
        check_val("start_dir", 32'(bus.dir), 32'd1);
        check_val("tick_c1", 32'(bus.tick), 32'd0);
        bus.start = 0;
        @(negedge clk);
        check_val("tick_c2", 32'(bus.tick), 32'd0);
        @(negedge clk);
        check_val("tick_c3", 32'(bus.tick), 32'd1);

        // Turn lands on a tick edge: STILL does not move.
        bus.right = 1;
        @(negedge clk);
        check_val("right_dir", 32'(bus.dir), 32'd4);
        check_val("right_no_move", 32'(bus.pos_x), 32'd300);
        wait_tick(n); @(negedge clk);
        check_val("move_301", 32'(bus.pos_x), 32'd301);
        wait_tick(n); @(negedge clk);
        check_val("move_302", 32'(bus.pos_x), 32'd302);
        check_val("rate_gap", 32'(n), 32'd3);
        wait_tick(n); @(negedge clk);
        check_val("move_303", 32'(bus.pos_x), 32'd303);
        check_val("rate_gap2", 32'(n), 32'd3);

        bus.right = 0; bus.up = 1; bus.blocked = 4'b0100;
        @(negedge clk);
        check_val("buf_pending", 32'(bus.pending), 32'd3);
        check_val("buf_dir", 32'(bus.dir), 32'd4);
        wait_tick(n); @(negedge clk);
        check_val("buf_moves", 32'(bus.pos_x), 32'd304);
        bus.up = 0; bus.blocked = 4'b0000;
        @(negedge clk);
        check_val("buf_take_dir", 32'(bus.dir), 32'd3);
        check_val("buf_take_pend", 32'(bus.pending), 32'd0);
        check_val("buf_pos_y", 32'(bus.pos_y), 32'd300);

        bus.left = 1;
        @(negedge clk);
        check_val("rev_left", 32'(bus.dir), 32'd2);
        bus.left = 0; bus.blocked = 4'b1000;
        @(negedge clk);
        check_val("wall_dir", 32'(bus.dir), 32'd1);
        repeat (3) begin
            wait_tick(n); @(negedge clk);
        end
        check_val("wall_pos_x", 32'(bus.pos_x), 32'd304);
        check_val("wall_dir_hold", 32'(bus.dir), 32'd1);

        bus.blocked = 4'b0000; bus.left = 1;
        @(negedge clk);
        check_val("left_dir", 32'(bus.dir), 32'd2);
        bus.left = 0;
        repeat (31) begin
            wait_tick(n); @(negedge clk);
        end
        check_val("at_x_min", 32'(bus.pos_x), 32'd273);
        wait_tick(n); @(negedge clk);
`ifdef SPRITE_MOVER_WRAP_EN
        x_edge = 663;
`else
        x_edge = 273;
`endif
        check_val("edge_x", 32'(bus.pos_x), 32'(x_edge));
        check_val("edge_y", 32'(bus.pos_y), 32'd300);

        bus.win = 1; bus.lose = 1;
        @(negedge clk);
        check_val("lose_dir", 32'(bus.dir), 32'd7);
        bus.win = 0; bus.lose = 0;
        wait_tick(n); @(negedge clk);
        check_val("lose_frozen", 32'(bus.pos_x), 32'(x_edge));
        bus.ack = 1;
        @(negedge clk);
        check_val("ack_dir", 32'(bus.dir), 32'd0);
        check_val("ack_pos_x", 32'(bus.pos_x), 32'd300);
        check_val("ack_pos_y", 32'(bus.pos_y), 32'd300);
        bus.ack = 0;

        bus.start = 1;
        @(negedge clk);
        bus.start = 0; bus.left = 1; bus.right = 1;
        @(negedge clk);
        check_val("multi_req", 32'(bus.dir), 32'd1);
        bus.left = 0; bus.right = 0; bus.win = 1;
        @(negedge clk);
        check_val("win_dir", 32'(bus.dir), 32'd6);
        bus.win = 0; bus.ack = 1;
        @(negedge clk);
        check_val("win_ack", 32'(bus.dir), 32'd0);
        bus.ack = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
